// File: rtl/approx_rc_adder_seq.sv
// Multi-cycle approximate ripple-carry adder: SEG bits per cycle, runtime-selectable approximate LSB count.
// Optional error-distance outputs enabled by defining APPROX_RC_ERR_DIST_EN.
module approx_rc_adder_seq #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4,
    parameter int KW    = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [KW-1:0]    approx_k,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum
`ifdef APPROX_RC_ERR_DIST_EN
    ,
    output logic [WIDTH:0]   err_dist,
    output logic             err_flag
`endif
);

    localparam int NSEG = WIDTH / SEG;
    localparam int CW   = (NSEG > 1) ? $clog2(NSEG) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] mask_r;
    logic             carry_r;
    logic [CW-1:0]    seg_cnt_r;

    logic [KW-1:0]    k_clamp_s;
    logic [WIDTH-1:0] mask_s;
    logic [SEG:0]     chain_s;
    logic [SEG-1:0]   seg_sum_s;
    logic [WIDTH-1:0] res_next_s;
    logic             last_seg_s;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Clamp k to WIDTH and expand it into a per-bit approximate-cell mask
    always_comb begin
        if (approx_k > KW'(WIDTH)) begin
            k_clamp_s = KW'(WIDTH);
        end else begin
            k_clamp_s = approx_k;
        end
        mask_s = '0;
        for (int i = 0; i < WIDTH; i++) begin
            mask_s[i] = (KW'(i) < k_clamp_s);
        end
    end

    // One segment of the cell chain; operand and mask registers are pre-shifted so bit 0 is the current LSB
    always_comb begin
        chain_s    = '0;
        seg_sum_s  = '0;
        chain_s[0] = carry_r;
        for (int j = 0; j < SEG; j++) begin
            if (mask_r[j]) begin
                seg_sum_s[j]   = ~chain_s[j];
                chain_s[j+1]   = 1'b0;
            end else begin
                seg_sum_s[j]   = a_r[j] ^ b_r[j] ^ chain_s[j];
                chain_s[j+1]   = maj3(a_r[j], b_r[j], chain_s[j]);
            end
        end
        last_seg_s = (seg_cnt_r == CW'(NSEG - 1));
    end

    // Partial result fills from the top, so after NSEG segments it is in natural bit order
    generate
        if (SEG == WIDTH) begin : g_one
            assign res_next_s = seg_sum_s;
        end else begin : g_multi
            logic [WIDTH-SEG-1:0] res_r;
            assign res_next_s = {seg_sum_s, res_r};

            // Holds the segments finished so far
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    res_r <= '0;
                end else if (state_r == BUSY) begin
                    res_r <= res_next_s[WIDTH-1:SEG];
                end else begin
                    res_r <= res_r;
                end
            end
        end
    endgenerate

`ifdef APPROX_RC_ERR_DIST_EN
    logic [WIDTH:0] exact_r;
    logic [WIDTH:0] final_s;
    assign final_s = {chain_s[SEG], res_next_s};
`endif

    // Control FSM with registered handshake outputs and result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            sum       <= '0;
            a_r       <= '0;
            b_r       <= '0;
            mask_r    <= '0;
            carry_r   <= 1'b0;
            seg_cnt_r <= '0;
`ifdef APPROX_RC_ERR_DIST_EN
            exact_r   <= '0;
            err_dist  <= '0;
            err_flag  <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        a_r       <= in1;
                        b_r       <= in2;
                        mask_r    <= mask_s;
                        carry_r   <= 1'b0;
                        seg_cnt_r <= '0;
                        in_ready  <= 1'b0;
                        state_r   <= BUSY;
`ifdef APPROX_RC_ERR_DIST_EN
                        exact_r   <= {1'b0, in1} + {1'b0, in2};
`endif
                    end else begin
                        in_ready  <= 1'b1;
                    end
                end
                BUSY: begin
                    a_r       <= a_r >> SEG;
                    b_r       <= b_r >> SEG;
                    mask_r    <= mask_r >> SEG;
                    carry_r   <= chain_s[SEG];
                    seg_cnt_r <= seg_cnt_r + CW'(1);
                    if (last_seg_s) begin
                        sum       <= {chain_s[SEG], res_next_s};
                        out_valid <= 1'b1;
                        state_r   <= DONE;
`ifdef APPROX_RC_ERR_DIST_EN
                        if (exact_r >= final_s) begin
                            err_dist <= exact_r - final_s;
                        end else begin
                            err_dist <= final_s - exact_r;
                        end
                        err_flag <= (exact_r != final_s);
`endif
                    end else begin
                        state_r   <= BUSY;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_r   <= IDLE;
                    end else begin
                        state_r   <= DONE;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_approx_rc_adder_seq.sv
// Self-checking bench for approx_rc_adder_seq (WIDTH=16, SEG=4); checks err_dist/err_flag when APPROX_RC_ERR_DIST_EN is defined.
module tb_approx_rc_adder_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in1 = 16'h0000;
    logic [15:0] in2 = 16'h0000;
    logic [4:0]  approx_k = 5'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [16:0] sum;
`ifdef APPROX_RC_ERR_DIST_EN
    logic [16:0] err_dist;
    logic        err_flag;
`endif

    int checks = 0;
    int failures = 0;

    approx_rc_adder_seq #(.WIDTH(16), .SEG(4), .KW(5)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in1(in1), .in2(in2), .approx_k(approx_k),
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum)
`ifdef APPROX_RC_ERR_DIST_EN
        , .err_dist(err_dist), .err_flag(err_flag)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Low k bits are all ones with no carry out; the rest is an exact add of the upper bits.
    function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b, input int k);
        int kk;
        logic [16:0] hi;
        logic [16:0] lo;
        kk = (k > 16) ? 16 : k;
        hi = ({1'b0, a} >> kk) + ({1'b0, b} >> kk);
        lo = (17'd1 << kk) - 17'd1;
        return (hi << kk) | lo;
    endfunction

    task automatic start_txn(input logic [15:0] a, input logic [15:0] b, input logic [4:0] k);
        int cyc;
        @(negedge clk);
        in1 = a; in2 = b; approx_k = k; in_valid = 1'b1;
        cyc = 0;
        while (in_ready !== 1'b1 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("accept_wait", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in1 = 16'($urandom); in2 = 16'($urandom); approx_k = 5'($urandom_range(31, 0));
    endtask

    task automatic wait_result(input string tag, input logic [16:0] exp);
        int cyc;
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 50) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk({tag, "_lat"}, 32'(cyc), 32'd4);
        chk({tag, "_sum"}, 32'(sum), 32'(exp));
    endtask

    task automatic consume(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_ovalid_clr"}, 32'(out_valid), 32'd0);
        chk({tag, "_iready_set"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] a;
        logic [15:0] b;
        logic [4:0]  k;
        logic [16:0] exp;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        start_txn(16'h1234, 16'h4321, 5'd0);
        wait_result("exact", 17'h05555);
`ifdef APPROX_RC_ERR_DIST_EN
        chk("exact_err", 32'(err_dist), 32'd0);
        chk("exact_flag", 32'(err_flag), 32'd0);
`endif
        consume("exact");

        start_txn(16'h0000, 16'h0000, 5'd10);
        wait_result("zero_k10", 17'h003FF);
`ifdef APPROX_RC_ERR_DIST_EN
        chk("zero_k10_err", 32'(err_dist), 32'h3FF);
`endif
        consume("zero_k10");

        start_txn(16'hFFFF, 16'h0001, 5'd10);
        wait_result("ffff_k10", 17'h0FFFF);
`ifdef APPROX_RC_ERR_DIST_EN
        chk("ffff_k10_err", 32'(err_dist), 32'd1);
        chk("ffff_k10_flag", 32'(err_flag), 32'd1);
`endif
        consume("ffff_k10");

        start_txn(16'hABCD, 16'h1357, 5'd31);
        wait_result("clamp", 17'h0FFFF);
        consume("clamp");

        start_txn(16'hFFFF, 16'hFFFF, 5'd16);
        wait_result("k_width", 17'h0FFFF);
        consume("k_width");

        // Hold result in DONE while a second request is presented
        exp = model(16'h00FF, 16'h0F01, 4);
        start_txn(16'h00FF, 16'h0F01, 5'd4);
        wait_result("hold", exp);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in1 = 16'($urandom); in2 = 16'($urandom); approx_k = 5'd0;
            @(posedge clk);
            #1;
            chk("hold_ovalid", 32'(out_valid), 32'd1);
            chk("hold_sum", 32'(sum), 32'(exp));
            chk("hold_iready", 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        consume("hold");
        start_txn(16'h8000, 16'h8000, 5'd0);
        wait_result("after_hold", 17'h10000);

        // Reset during the second BUSY cycle, with a nonzero result still held
        out_ready = 1'b1;
        start_txn(16'hFFFF, 16'hFFFF, 5'd0);
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_ovalid", 32'(out_valid), 32'd0);
        chk("midrst_sum", 32'(sum), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("postrst_iready", 32'(in_ready), 32'd1);
        chk("postrst_ovalid", 32'(out_valid), 32'd0);
        start_txn(16'h0001, 16'h0001, 5'd0);
        wait_result("postrst", 17'h00002);
        consume("postrst");

        for (int t = 0; t < 40; t++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            k = 5'($urandom_range(31, 0));
            start_txn(a, b, k);
            wait_result("rand", model(a, b, int'(k)));
            repeat ($urandom_range(2, 0)) @(posedge clk);
            consume("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
